// File: rtl/fp_div_issuer.sv
// In-order tag issuer and result reorder buffer for a shared fixed-latency FP divider.
// Optional macro FP_DIV_ISSUE_ERR_CHECK_EN enables the sticky err_o protocol check.
module fp_div_issuer #(
    parameter int TAG_WIDTH  = 2,
    parameter int FP_WIDTH   = 32,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [FP_WIDTH-1:0]   req_opa_i,
    input  logic [FP_WIDTH-1:0]   req_opb_i,
    input  logic [RND_WIDTH-1:0]  req_rnd_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [FP_WIDTH-1:0]   rsp_res_o,
    output logic [STAT_WIDTH-1:0] rsp_status_o,
    output logic                  div_en_o,
    output logic [FP_WIDTH-1:0]   div_opa_o,
    output logic [FP_WIDTH-1:0]   div_opb_o,
    output logic [TAG_WIDTH-1:0]  div_tag_o,
    output logic [RND_WIDTH-1:0]  div_rnd_o,
    input  logic                  div_valid_i,
    input  logic [FP_WIDTH-1:0]   div_res_i,
    input  logic [TAG_WIDTH-1:0]  div_tag_i,
    input  logic [STAT_WIDTH-1:0] div_status_i,
    output logic                  err_o
);
    localparam int DEPTH = 1 << TAG_WIDTH;

    logic [TAG_WIDTH-1:0]  r_wr_ptr;
    logic [TAG_WIDTH-1:0]  r_rd_ptr;
    logic [TAG_WIDTH:0]    r_count;
    logic [FP_WIDTH-1:0]   r_res  [DEPTH];
    logic [STAT_WIDTH-1:0] r_stat [DEPTH];
    logic [DEPTH-1:0]      r_done;

    logic                  r_div_en;
    logic [FP_WIDTH-1:0]   r_div_opa;
    logic [FP_WIDTH-1:0]   r_div_opb;
    logic [TAG_WIDTH-1:0]  r_div_tag;
    logic [RND_WIDTH-1:0]  r_div_rnd;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_retire;
    logic [TAG_WIDTH-1:0]  w_off;
    logic                  w_outst;
    logic                  w_ret_ok;
    logic [DEPTH-1:0]      w_done_nxt;

    // count never exceeds DEPTH, so its MSB alone marks the full state
    assign w_ready  = ~r_count[TAG_WIDTH];
    assign w_accept = req_valid_i & w_ready;
    assign w_retire = r_done[r_rd_ptr] & rsp_ready_i;
    assign w_off    = div_tag_i - r_rd_ptr;
    assign w_outst  = {1'b0, w_off} < r_count;
    assign w_ret_ok = div_valid_i & w_outst & ~r_done[div_tag_i];

    always_comb begin
        w_done_nxt = r_done;
        if (w_retire) w_done_nxt[r_rd_ptr] = 1'b0;
        if (w_ret_ok) w_done_nxt[div_tag_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_done    <= '0;
            r_div_en  <= 1'b0;
            r_div_opa <= '0;
            r_div_opb <= '0;
            r_div_tag <= '0;
            r_div_rnd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i]  <= '0;
                r_stat[i] <= '0;
            end
        end else begin
            r_done   <= w_done_nxt;
            r_div_en <= w_accept;
            if (w_accept) begin
                r_div_opa <= req_opa_i;
                r_div_opb <= req_opb_i;
                r_div_tag <= r_wr_ptr;
                r_div_rnd <= req_rnd_i;
                r_wr_ptr  <= r_wr_ptr + TAG_WIDTH'(1);
            end
            if (w_retire) r_rd_ptr <= r_rd_ptr + TAG_WIDTH'(1);
            if (w_ret_ok) begin
                r_res[div_tag_i]  <= div_res_i;
                r_stat[div_tag_i] <= div_status_i;
            end
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + (TAG_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (TAG_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FP_DIV_ISSUE_ERR_CHECK_EN
    logic r_err;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_err <= 1'b0;
        else if (div_valid_i & ~w_ret_ok) r_err <= 1'b1;
    end
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign req_ready_o  = w_ready;
    assign rsp_valid_o  = r_done[r_rd_ptr];
    assign rsp_res_o    = r_res[r_rd_ptr];
    assign rsp_status_o = r_stat[r_rd_ptr];
    assign div_en_o     = r_div_en;
    assign div_opa_o    = r_div_opa;
    assign div_opb_o    = r_div_opb;
    assign div_tag_o    = r_div_tag;
    assign div_rnd_o    = r_div_rnd;

endmodule

// File: tb/tb_fp_div_issuer.sv
// Directed bench for fp_div_issuer; the divider is emulated by driving tagged returns.
// Expected err_o follows FP_DIV_ISSUE_ERR_CHECK_EN.
module tb_fp_div_issuer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_opa_i;
    logic [31:0] req_opb_i;
    logic [2:0]  req_rnd_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_res_o;
    logic [7:0]  rsp_status_o;
    logic        div_en_o;
    logic [31:0] div_opa_o;
    logic [31:0] div_opb_o;
    logic [1:0]  div_tag_o;
    logic [2:0]  div_rnd_o;
    logic        div_valid_i;
    logic [31:0] div_res_i;
    logic [1:0]  div_tag_i;
    logic [7:0]  div_status_i;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    logic exp_err;

    fp_div_issuer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_opa_i(req_opa_i), .req_opb_i(req_opb_i), .req_rnd_i(req_rnd_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_res_o(rsp_res_o), .rsp_status_o(rsp_status_o),
        .div_en_o(div_en_o), .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
        .div_tag_o(div_tag_o), .div_rnd_o(div_rnd_o),
        .div_valid_i(div_valid_i), .div_res_i(div_res_i),
        .div_tag_i(div_tag_i), .div_status_i(div_status_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        req_valid_i = 0; req_opa_i = 0; req_opb_i = 0; req_rnd_i = 0;
        rsp_ready_i = 0;
        div_valid_i = 0; div_res_i = 0; div_tag_i = 0; div_status_i = 0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        req_valid_i = 1; req_opa_i = a; req_opb_i = b;
        step();
        req_valid_i = 0;
    endtask

    task automatic ret(input logic [1:0] t, input logic [31:0] r,
                       input logic [7:0] s);
        div_valid_i = 1; div_tag_i = t; div_res_i = r; div_status_i = s;
        step();
        div_valid_i = 0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %b exp 1", req_ready_o);
        end
        checks++;
        if ({rsp_valid_o, div_en_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags got %b exp 000", {rsp_valid_o, div_en_o, err_o});
        end
        checks++;
        if ({div_opa_o, div_opb_o, div_tag_o, div_rnd_o, rsp_res_o, rsp_status_o} !== '0) begin
            errors++; $display("FAIL rst_data got nonzero exp 0");
        end
    endtask

    task automatic test_single;
        do_reset();
        rsp_ready_i = 1;
        req_valid_i = 1; req_opa_i = 32'h40400000; req_opb_i = 32'h40000000;
        req_rnd_i = 0;
        step();
        req_valid_i = 0;
        checks++;
        if ({div_en_o, div_tag_o} !== 3'b100) begin
            errors++; $display("FAIL single_en got %b exp 100", {div_en_o, div_tag_o});
        end
        checks++;
        if (div_opa_o !== 32'h40400000 || div_opb_o !== 32'h40000000) begin
            errors++; $display("FAIL single_ops got %h/%h exp 40400000/40000000",
                               div_opa_o, div_opb_o);
        end
        req_opa_i = 32'h12345678;
        step();
        checks++;
        if (div_en_o !== 1'b0 || div_opa_o !== 32'h40400000) begin
            errors++; $display("FAIL single_hold got en=%b opa=%h exp 0/40400000",
                               div_en_o, div_opa_o);
        end
        step();
        div_valid_i = 1; div_tag_i = 0; div_res_i = 32'h3FC00000; div_status_i = 0;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL single_early got %b exp 0", rsp_valid_o);
        end
        step();
        div_valid_i = 0;
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_res_o !== 32'h3FC00000) begin
            errors++; $display("FAIL single_rsp got v=%b res=%h exp 1/3fc00000",
                               rsp_valid_o, rsp_res_o);
        end
        step();
        checks++;
        if (rsp_valid_o !== 1'b0 || dut.r_count !== 3'd0) begin
            errors++; $display("FAIL single_done got v=%b cnt=%0d exp 0/0",
                               rsp_valid_o, dut.r_count);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        rsp_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready_o !== 1'b1) begin
                errors++; $display("FAIL b2b_ready%0d got 0 exp 1", i);
            end
            req_valid_i = 1; req_opa_i = 32'h100 + i; req_rnd_i = 3'(i);
            step();
            checks++;
            if (div_en_o !== 1'b1 || div_tag_o !== 2'(i) || div_rnd_o !== 3'(i)) begin
                errors++; $display("FAIL b2b_tag%0d got en=%b tag=%0d rnd=%0d exp 1/%0d/%0d",
                                   i, div_en_o, div_tag_o, div_rnd_o, i, i);
            end
        end
        checks++;
        if (req_ready_o !== 1'b0) begin
            errors++; $display("FAIL b2b_full got %b exp 0", req_ready_o);
        end
        req_valid_i = 1;
        step();
        req_valid_i = 0;
        checks++;
        if (div_en_o !== 1'b0) begin
            errors++; $display("FAIL b2b_noacc got %b exp 0", div_en_o);
        end
        for (int i = 0; i < 4; i++) ret(2'(i), 32'h1000 + i, 8'(i));
        checks++;
        if (req_ready_o !== 1'b0 || rsp_res_o !== 32'h1000) begin
            errors++; $display("FAIL b2b_stall got rdy=%b res=%h exp 0/1000",
                               req_ready_o, rsp_res_o);
        end
        rsp_ready_i = 1;
        step();
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_free got %b exp 1", req_ready_o);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_res_o !== 32'h1000 + i) begin
                errors++; $display("FAIL b2b_order%0d got v=%b res=%h exp 1/%h",
                                   i, rsp_valid_o, rsp_res_o, 32'h1000 + i);
            end
            step();
        end
        checks++;
        if (rsp_valid_o !== 1'b0 || dut.r_count !== 3'd0) begin
            errors++; $display("FAIL b2b_empty got v=%b cnt=%0d exp 0/0",
                               rsp_valid_o, dut.r_count);
        end
    endtask

    task automatic test_out_of_order;
        do_reset();
        rsp_ready_i = 0;
        for (int i = 0; i < 3; i++) issue(32'h200 + i, 32'h1);
        ret(2'd2, 32'hA2, 8'h22);
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL ooo_wait got %b exp 0", rsp_valid_o);
        end
        ret(2'd0, 32'hA0, 8'h20);
        ret(2'd1, 32'hA1, 8'h21);
        step();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_res_o !== 32'hA0) begin
            errors++; $display("FAIL ooo_stable got v=%b res=%h exp 1/a0",
                               rsp_valid_o, rsp_res_o);
        end
        rsp_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_res_o !== 32'hA0 + i ||
                rsp_status_o !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL ooo_rsp%0d got v=%b res=%h st=%h exp 1/%h/%h",
                                   i, rsp_valid_o, rsp_res_o, rsp_status_o,
                                   32'hA0 + i, 8'h20 + 8'(i));
            end
            step();
        end
        rsp_ready_i = 0;
    endtask

    task automatic test_wrap;
        do_reset();
        rsp_ready_i = 0;
        for (int i = 0; i < 3; i++) issue(32'h300 + i, 32'h1);
        for (int i = 0; i < 3; i++) ret(2'(i), 32'hB0 + i, 8'h0);
        rsp_ready_i = 1;
        step();
        req_valid_i = 1;
        checks++;
        if (rsp_res_o !== 32'hB1 || dut.r_count !== 3'd2) begin
            errors++; $display("FAIL wrap_pre got res=%h cnt=%0d exp b1/2",
                               rsp_res_o, dut.r_count);
        end
        step();
        checks++;
        if (div_tag_o !== 2'd3 || dut.r_count !== 3'd2 || rsp_res_o !== 32'hB2) begin
            errors++; $display("FAIL wrap_both1 got tag=%0d cnt=%0d res=%h exp 3/2/b2",
                               div_tag_o, dut.r_count, rsp_res_o);
        end
        step();
        req_valid_i = 0;
        checks++;
        if (div_tag_o !== 2'd0 || dut.r_count !== 3'd2 || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL wrap_both2 got tag=%0d cnt=%0d v=%b exp 0/2/0",
                               div_tag_o, dut.r_count, rsp_valid_o);
        end
        ret(2'd3, 32'hB3, 8'h3);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_res_o !== 32'hB3) begin
            errors++; $display("FAIL wrap_t3 got v=%b res=%h exp 1/b3",
                               rsp_valid_o, rsp_res_o);
        end
        ret(2'd0, 32'hC0, 8'h4);
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_res_o !== 32'hC0 || dut.r_count !== 3'd1) begin
            errors++; $display("FAIL wrap_rd0 got v=%b res=%h cnt=%0d exp 1/c0/1",
                               rsp_valid_o, rsp_res_o, dut.r_count);
        end
        step();
        checks++;
        if (rsp_valid_o !== 1'b0 || dut.r_count !== 3'd0) begin
            errors++; $display("FAIL wrap_end got v=%b cnt=%0d exp 0/0",
                               rsp_valid_o, dut.r_count);
        end
        rsp_ready_i = 0;
    endtask

    task automatic test_err;
        do_reset();
        ret(2'd1, 32'hDEAD, 8'hFF);
        checks++;
        if (err_o !== exp_err) begin
            errors++; $display("FAIL err_set got %b exp %b", err_o, exp_err);
        end
        step();
        step();
        checks++;
        if (err_o !== exp_err || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL err_hold got err=%b v=%b exp %b/0",
                               err_o, rsp_valid_o, exp_err);
        end
        issue(32'h1, 32'h2);
        issue(32'h3, 32'h4);
        ret(2'd0, 32'h11, 8'h1);
        ret(2'd0, 32'h99, 8'h9);
        checks++;
        if (rsp_res_o !== 32'h11 || rsp_status_o !== 8'h1) begin
            errors++; $display("FAIL err_dup got res=%h st=%h exp 11/01",
                               rsp_res_o, rsp_status_o);
        end
        rsp_ready_i = 1;
        step();
        rsp_ready_i = 0;
        checks++;
        if (rsp_valid_o !== 1'b0 || err_o !== exp_err) begin
            errors++; $display("FAIL err_nowrite got v=%b err=%b exp 0/%b",
                               rsp_valid_o, err_o, exp_err);
        end
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b exp 0", err_o);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 3; i++) issue(32'h400 + i, 32'h1);
        ret(2'd0, 32'hE0, 8'h0);
        rst_i = 1;
        step();
        rst_i = 0;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || div_en_o !== 1'b0 ||
            dut.r_count !== 3'd0) begin
            errors++; $display("FAIL mid_rst got rdy=%b v=%b en=%b cnt=%0d exp 1/0/0/0",
                               req_ready_o, rsp_valid_o, div_en_o, dut.r_count);
        end
        ret(2'd1, 32'hE1, 8'h0);
        checks++;
        if (rsp_valid_o !== 1'b0 || err_o !== exp_err) begin
            errors++; $display("FAIL mid_stale got v=%b err=%b exp 0/%b",
                               rsp_valid_o, err_o, exp_err);
        end
        do_reset();
    endtask

    initial begin
`ifdef FP_DIV_ISSUE_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_order();
        test_wrap();
        test_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/fp_div_issuer.md
# fp_div_issuer

Initiator-side companion for the shared-APU FP divider. It accepts divide requests from a core port with a valid/ready handshake and assigns each one a tag from a circular pool. It drives the divider's enable/operand/tag/rounding inputs, collects tagged results into a per-tag buffer, and returns them to the core strictly in issue order. The block sits between a core's APU request port and one fixed-latency, always-ready FP divider instance.

## Interface
- TAG_WIDTH, 2, tag width; DEPTH = 2**TAG_WIDTH outstanding operations max
- FP_WIDTH, 32, operand/result width
- RND_WIDTH, 3, rounding-mode width
- STAT_WIDTH, 8, divider status-flag width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  issuer can accept a request
- req_opa_i, req_opb_i  in  FP_WIDTH  dividend, divisor
- req_rnd_i  in  RND_WIDTH  rounding mode
- rsp_valid_o  out  1  in-order result available
- rsp_ready_i  in  1  core takes result
- rsp_res_o  out  FP_WIDTH  quotient
- rsp_status_o  out  STAT_WIDTH  divider status flags
- div_en_o  out  1  divider enable, one-cycle pulse per operation
- div_opa_o, div_opb_o  out  FP_WIDTH  divider operands
- div_tag_o  out  TAG_WIDTH  tag of issued operation
- div_rnd_o  out  RND_WIDTH  divider rounding mode
- div_valid_i  in  1  divider result valid
- div_res_i  in  FP_WIDTH  divider result
- div_tag_i  in  TAG_WIDTH  tag of returned result
- div_status_i  in  STAT_WIDTH  divider status
- err_o  out  1  sticky protocol error

## Operation
- State: wr_ptr and rd_ptr (TAG_WIDTH bits, wrap modulo DEPTH), count (TAG_WIDTH+1 bits, 0..DEPTH), and per-tag buffer entries {res, status, done}.
- req_ready_o = (count != DEPTH), decoded from the registered count.
- Accept (req_valid_i & req_ready_o):
  - Next cycle, div_en_o = 1, div_tag_o = wr_ptr, and operands/rnd are driven from the request.
  - wr_ptr increments.
- Cycles with no accept: div_en_o = 0. Operand, tag and rnd outputs hold their last value.
- A tag t is outstanding iff ((t - rd_ptr) mod DEPTH) < count.
- Return (div_valid_i): if div_tag_i is outstanding and not done, write res/status to entry div_tag_i and set done. Otherwise drop the return and raise the protocol error.
- rsp_valid_o = done[rd_ptr]; rsp_res_o and rsp_status_o come combinationally from entry rd_ptr.
- Retire (rsp_valid_o & rsp_ready_i): clear done[rd_ptr] and increment rd_ptr.
- count update: +1 on accept only, -1 on retire only, unchanged when both occur in the same cycle.
- Full (count == DEPTH): req_ready_o = 0. A retire frees the slot from the next cycle on; there is no same-cycle pass-through.
- Empty (count == 0): rsp_valid_o = 0. Any div_valid_i is dropped and flagged.
- Out-of-order returns are buffered. The response order to the core remains issue order.
- Returns to any tag are accepted while the core stalls rsp_ready_i.

## Timing
- Reset values: req_ready_o = 1, rsp_valid_o = 0, div_en_o = 0, err_o = 0, all data outputs = 0; pointers, count and done bits all 0.
- Reset mid-operation:
  - All in-flight state is discarded.
  - The divider must be reset in the same cycle.
  - Any stale div_valid_i after reset is dropped (and flagged per Configuration).
- Accept in cycle N → div_en_o in N+1.
- With the 2-register divider, div_valid_i arrives in N+3, giving rsp_valid_o in N+4. Minimum request-to-response latency is 4 cycles.
- Throughput: one accept and one retire per cycle, sustained while count < DEPTH.
- rsp outputs stay stable while rsp_valid_o = 1 and rsp_ready_i = 0.

## Configuration
- FP_DIV_ISSUE_ERR_CHECK_EN defined:
  - err_o goes high the cycle after a div_valid_i with a non-outstanding or already-done tag.
  - err_o stays high until rst_i.
- FP_DIV_ISSUE_ERR_CHECK_EN undefined:
  - err_o is tied to 0 and the check logic is absent.
  - Invalid returns are still dropped and never overwrite a done entry.

## Test plan
- Single op, A=0x40400000 (3.0), B=0x40000000 (2.0), rnd=0: div_en_o and div_tag_o=0 in cycle 1; result 0x3FC00000 returned on rsp in cycle 4; count back to 0.
- Back-to-back accepts with rsp_ready_i=0 and TAG_WIDTH=2: 4 accepted with tags 0,1,2,3; req_ready_o falls after the 4th; releasing rsp_ready_i retires in order, and req_ready_o rises one cycle after the first retire.
- Divider model returns tags 2,0,1 out of order: rsp delivers tag 0, then 1, then 2 results with matching status.
- Accept and retire in the same cycle at count=2: count stays 2, and wr_ptr/rd_ptr wrap 3→0 correctly.
- With the macro defined: div_valid_i with tag 1 while count=0 → drop, err_o=1 next cycle and held; rst_i clears it to 0. Same stimulus without the macro → err_o stays 0 and the buffer is unchanged.
- rst_i pulsed with 3 ops outstanding: the next cycle shows req_ready_o=1, rsp_valid_o=0, and a stale div_valid_i is ignored.
